// File: rtl/laser_safety_pkg.sv
// Shared types and constants for the laser safety sequencer.
//   state_e      : FSM state encodings (3 bits, exported on the state port)
//   FLT_*        : bit positions within the sticky fault code
//   FAULT_W      : fault code width
//   max3()       : helper used to size the shared control timer
package laser_safety_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ARMING      = 3'd1,
    ST_ARMED       = 3'd2,
    ST_TRIPPED     = 3'd3,
    ST_CLEAR_PULSE = 3'd4,
    ST_CLEAR_HOLD  = 3'd5
  } state_e;

  localparam int FAULT_W        = 5;
  localparam int FLT_PULSE_LO   = 0;
  localparam int FLT_PULSE_HI   = 1;
  localparam int FLT_RATE_LO    = 2;
  localparam int FLT_CURRENT    = 3;
  localparam int FLT_READY_LOST = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ctrl_timer.sv
// Loadable down-counter shared by the ARMING, CLEAR_PULSE and CLEAR_HOLD
// phases. Load wins over decrement; the count parks at zero.
//   clk, rstn : clock, async active-low reset
//   load      : load strobe, load_val is taken on the next edge
//   dec       : decrement enable (ignored once at zero)
//   zero      : count is zero
module ctrl_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/laser_safety_sequencer.sv
// Sequences the laser pulse/current limit checker: arms the laser after a
// settle period with laser_ready high, drops enable on any checker fail or
// loss of ready, latches a sticky fault code and runs the clear handshake
// (clear_fail pulse, holdoff, re-check of the fail flags).
//   clk, rstn                 : clock, async active-low reset
//   arm_req/disarm_req/clear_req : host requests, sampled each cycle
//   laser_ready               : laser driver ready
//   *_limit_fail              : checker fail flags
//   laser_enable, clear_fail  : registered controls to driver / checker
//   fault_code                : sticky fault bits (see FLT_* in the package)
//   trip_pulse, trip_count    : strobe and saturating count of TRIPPED entries
//   state                     : current FSM state
module laser_safety_sequencer
  import laser_safety_pkg::*;
#(
  parameter int ARM_SETTLE_CYCLES    = 1000,
  parameter int CLEAR_PULSE_CYCLES   = 4,
  parameter int CLEAR_HOLDOFF_CYCLES = 16,
  parameter int TRIP_CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  arm_req,
  input  logic                  disarm_req,
  input  logic                  clear_req,
  input  logic                  laser_ready,
  input  logic                  pulse_lower_limit_fail,
  input  logic                  pulse_upper_limit_fail,
  input  logic                  rate_lower_limit_fail,
  input  logic                  current_limit_fail,
  output logic                  laser_enable,
  output logic                  clear_fail,
  output logic [FAULT_W-1:0]    fault_code,
  output logic                  trip_pulse,
  output logic [TRIP_CNT_W-1:0] trip_count,
  output logic [2:0]            state
);

  localparam int TW = $clog2(max3(ARM_SETTLE_CYCLES, CLEAR_PULSE_CYCLES,
                                  CLEAR_HOLDOFF_CYCLES)) + 1;
  localparam logic [TW-1:0] ARM_LOAD  = TW'(ARM_SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] PULS_LOAD = TW'(CLEAR_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(CLEAR_HOLDOFF_CYCLES - 1);

  state_e               state_q, state_d;
  logic [FAULT_W-1:0]   flags, fault_d;
  logic                 any_fail, enter_trip;
  logic                 t_load, t_dec, t_zero;
  logic [TW-1:0]        t_load_val;

  // Checker flags mapped onto fault-code positions; ready_lost is set only
  // by the FSM, so that slot stays zero here.
  always_comb begin
    flags                 = '0;
    flags[FLT_PULSE_LO]   = pulse_lower_limit_fail;
    flags[FLT_PULSE_HI]   = pulse_upper_limit_fail;
    flags[FLT_RATE_LO]    = rate_lower_limit_fail;
    flags[FLT_CURRENT]    = current_limit_fail;
  end
  assign any_fail = |flags;

  ctrl_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (t_load),
    .load_val (t_load_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  // Priority inside each state: fail > disarm > clear > arm.
  always_comb begin
    state_d    = state_q;
    fault_d    = fault_code;
    t_load     = 1'b0;
    t_load_val = '0;
    t_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_fail) begin
          state_d = ST_TRIPPED;
          fault_d = fault_code | flags;
        end else if (arm_req && laser_ready) begin
          state_d    = ST_ARMING;
          t_load     = 1'b1;
          t_load_val = ARM_LOAD;
        end
      end
      ST_ARMING: begin
        if (any_fail) begin
          state_d = ST_TRIPPED;
          fault_d = fault_code | flags;
        end else if (disarm_req) begin
          state_d = ST_IDLE;
        end else if (!laser_ready) begin
          // settle period restarts whenever ready dips
          t_load     = 1'b1;
          t_load_val = ARM_LOAD;
        end else if (t_zero) begin
          state_d = ST_ARMED;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_ARMED: begin
        if (any_fail) begin
          state_d = ST_TRIPPED;
          fault_d = fault_code | flags;
        end else if (!laser_ready) begin
          state_d                 = ST_TRIPPED;
          fault_d[FLT_READY_LOST] = 1'b1;
        end else if (disarm_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_TRIPPED: begin
        fault_d = fault_code | flags;
        if (clear_req) begin
          state_d    = ST_CLEAR_PULSE;
          t_load     = 1'b1;
          t_load_val = PULS_LOAD;
        end
      end
      ST_CLEAR_PULSE: begin
        // checker is being reset; its flags are meaningless here
        if (t_zero) begin
          state_d    = ST_CLEAR_HOLD;
          t_load     = 1'b1;
          t_load_val = HOLD_LOAD;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_CLEAR_HOLD: begin
        if (t_zero) begin
          if (any_fail) begin
            state_d = ST_TRIPPED;
            fault_d = fault_code | flags;
          end else begin
            state_d = ST_IDLE;
            fault_d = '0;
          end
        end else begin
          t_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_trip = (state_d == ST_TRIPPED) && (state_q != ST_TRIPPED);

  // Outputs are decoded from the next state so they change on the same edge
  // as the transition (enable is high on the first ARMED cycle, low on the
  // first TRIPPED cycle).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      laser_enable <= 1'b0;
      clear_fail   <= 1'b0;
      fault_code   <= '0;
      trip_pulse   <= 1'b0;
      trip_count   <= '0;
    end else begin
      state_q      <= state_d;
      laser_enable <= (state_d == ST_ARMED);
      clear_fail   <= (state_d == ST_CLEAR_PULSE);
      fault_code   <= fault_d;
      trip_pulse   <= enter_trip;
      if (enter_trip && !(&trip_count))
        trip_count <= trip_count + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_laser_safety_sequencer.sv
module tb_laser_safety_sequencer;

  logic clk, rstn;
  logic arm_req, disarm_req, clear_req, laser_ready;
  logic pulse_lower_limit_fail, pulse_upper_limit_fail;
  logic rate_lower_limit_fail, current_limit_fail;
  logic       laser_enable, clear_fail, trip_pulse;
  logic [4:0] fault_code;
  logic [1:0] trip_count;
  logic [2:0] state;

  laser_safety_sequencer #(
    .ARM_SETTLE_CYCLES    (8),
    .CLEAR_PULSE_CYCLES   (4),
    .CLEAR_HOLDOFF_CYCLES (16),
    .TRIP_CNT_W           (2)
  ) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .arm_req                (arm_req),
    .disarm_req             (disarm_req),
    .clear_req              (clear_req),
    .laser_ready            (laser_ready),
    .pulse_lower_limit_fail (pulse_lower_limit_fail),
    .pulse_upper_limit_fail (pulse_upper_limit_fail),
    .rate_lower_limit_fail  (rate_lower_limit_fail),
    .current_limit_fail     (current_limit_fail),
    .laser_enable           (laser_enable),
    .clear_fail             (clear_fail),
    .fault_code             (fault_code),
    .trip_pulse             (trip_pulse),
    .trip_count             (trip_count),
    .state                  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       clr;
    logic [4:0] fc;
    logic       tp;
    logic [1:0] tc;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  e;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic obs_t o(input logic [2:0] st, input logic en, input logic clr,
                             input logic [4:0] fc, input logic tp, input logic [1:0] tc);
    obs_t r;
    r = {st, en, clr, fc, tp, tc};
    return r;
  endfunction

  function automatic obs_t cur();
    obs_t r;
    r = {state, laser_enable, clear_fail, fault_code, trip_pulse, trip_count};
    return r;
  endfunction

  task automatic push(input string tag, input obs_t e);
    exp_t it;
    it.tag = tag;
    it.e   = e;
    q.push_back(it);
  endtask

  task automatic check_now();
    exp_t it;
    while (q.size() > 0) begin
      it = q.pop_front();
      total++;
      assert (cur() === it.e) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", it.tag, cur(), it.e);
      end
    end
  endtask

  // advance one edge, then compare everything queued for it
  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  // Clear handshake from TRIPPED: 4 pulse cycles, 16 holdoff cycles, then
  // IDLE (sticky=0) or back to TRIPPED (sticky=1). Stray flags are injected
  // during the pulse and mid-holdoff; they must not be latched.
  task automatic run_clear(input logic [4:0] fc, input logic [1:0] tc,
                           input logic sticky, input logic [1:0] tc_end);
    clear_req = 1'b1;
    push("clr_enter", o(3'd4, 1'b0, 1'b1, fc, 1'b0, tc));
    tick();
    clear_req = 1'b0;
    current_limit_fail = 1'b0;
    pulse_upper_limit_fail = 1'b1;
    push("clr_pulse_ign", o(3'd4, 1'b0, 1'b1, fc, 1'b0, tc));
    tick();
    pulse_upper_limit_fail = 1'b0;
    repeat (2) begin
      push("clr_pulse", o(3'd4, 1'b0, 1'b1, fc, 1'b0, tc));
      tick();
    end
    push("hold_enter", o(3'd5, 1'b0, 1'b0, fc, 1'b0, tc));
    tick();
    for (int i = 0; i < 15; i++) begin
      if (i == 5) pulse_lower_limit_fail = 1'b1;
      push("hold", o(3'd5, 1'b0, 1'b0, fc, 1'b0, tc));
      tick();
      pulse_lower_limit_fail = 1'b0;
    end
    if (sticky) push("clr_sticky", o(3'd3, 1'b0, 1'b0, fc, 1'b1, tc_end));
    else        push("clr_done",   o(3'd0, 1'b0, 1'b0, 5'b0, 1'b0, tc));
    tick();
  endtask

  // arm from IDLE with ready high and wait out the 8-cycle settle
  task automatic arm_seq(input logic [1:0] tc);
    arm_req = 1'b1;
    push("arm_enter", o(3'd1, 1'b0, 1'b0, 5'b0, 1'b0, tc));
    tick();
    arm_req = 1'b0;
    repeat (7) begin
      push("arming", o(3'd1, 1'b0, 1'b0, 5'b0, 1'b0, tc));
      tick();
    end
    push("armed", o(3'd2, 1'b1, 1'b0, 5'b0, 1'b0, tc));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    arm_req = 1'b0; disarm_req = 1'b0; clear_req = 1'b0; laser_ready = 1'b1;
    pulse_lower_limit_fail = 1'b0; pulse_upper_limit_fail = 1'b0;
    rate_lower_limit_fail = 1'b0; current_limit_fail = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", o(3'd0, 1'b0, 1'b0, 5'b0, 1'b0, 2'd0));
    check_now();
    rstn = 1'b1;

    // arm: enable exactly 8 edges after the arm_req edge
    arm_seq(2'd0);
    push("armed_stay", o(3'd2, 1'b1, 1'b0, 5'b0, 1'b0, 2'd0));
    tick();

    // current fail together with disarm: fail wins
    current_limit_fail = 1'b1; disarm_req = 1'b1;
    push("trip_cur", o(3'd3, 1'b0, 1'b0, 5'b01000, 1'b1, 2'd1));
    tick();
    current_limit_fail = 1'b0; disarm_req = 1'b1; arm_req = 1'b1;
    push("trip_ignore_req", o(3'd3, 1'b0, 1'b0, 5'b01000, 1'b0, 2'd1));
    tick();
    disarm_req = 1'b0; arm_req = 1'b0;
    run_clear(5'b01000, 2'd1, 1'b0, 2'd1);

    // rate fail from IDLE, then clear with rate held and a new current fail
    rate_lower_limit_fail = 1'b1;
    push("trip_rate", o(3'd3, 1'b0, 1'b0, 5'b00100, 1'b1, 2'd2));
    tick();
    push("trip_rate_stay", o(3'd3, 1'b0, 1'b0, 5'b00100, 1'b0, 2'd2));
    tick();
    current_limit_fail = 1'b1;
    run_clear(5'b01100, 2'd2, 1'b1, 2'd3);
    rate_lower_limit_fail = 1'b0;
    push("sticky_no_repulse", o(3'd3, 1'b0, 1'b0, 5'b01100, 1'b0, 2'd3));
    tick();
    run_clear(5'b01100, 2'd3, 1'b0, 2'd3);

    // ready dips in ARMING: settle restarts from full count
    arm_req = 1'b1;
    push("arm2_enter", o(3'd1, 1'b0, 1'b0, 5'b0, 1'b0, 2'd3));
    tick();
    arm_req = 1'b0;
    repeat (2) begin
      push("arm2_wait", o(3'd1, 1'b0, 1'b0, 5'b0, 1'b0, 2'd3));
      tick();
    end
    laser_ready = 1'b0;
    repeat (3) begin
      push("arm2_reload", o(3'd1, 1'b0, 1'b0, 5'b0, 1'b0, 2'd3));
      tick();
    end
    laser_ready = 1'b1;
    repeat (7) begin
      push("arm2_resettle", o(3'd1, 1'b0, 1'b0, 5'b0, 1'b0, 2'd3));
      tick();
    end
    push("arm2_armed", o(3'd2, 1'b1, 1'b0, 5'b0, 1'b0, 2'd3));
    tick();

    // ready lost in ARMED; trip_count saturated at 3
    laser_ready = 1'b0;
    push("trip_ready", o(3'd3, 1'b0, 1'b0, 5'b10000, 1'b1, 2'd3));
    tick();
    laser_ready = 1'b1;
    push("trip_ready_stay", o(3'd3, 1'b0, 1'b0, 5'b10000, 1'b0, 2'd3));
    tick();
    run_clear(5'b10000, 2'd3, 1'b0, 2'd3);

    // arm with ready low is ignored
    laser_ready = 1'b0; arm_req = 1'b1;
    push("arm_no_ready", o(3'd0, 1'b0, 1'b0, 5'b0, 1'b0, 2'd3));
    tick();
    laser_ready = 1'b1; arm_req = 1'b0;

    // two flags in one cycle latch both bits
    pulse_lower_limit_fail = 1'b1; pulse_upper_limit_fail = 1'b1;
    push("trip_multi", o(3'd3, 1'b0, 1'b0, 5'b00011, 1'b1, 2'd3));
    tick();
    pulse_lower_limit_fail = 1'b0; pulse_upper_limit_fail = 1'b0;
    push("trip_multi_stay", o(3'd3, 1'b0, 1'b0, 5'b00011, 1'b0, 2'd3));
    tick();
    run_clear(5'b00011, 2'd3, 1'b0, 2'd3);

    // async reset mid-ARMED drops enable with no clock edge
    arm_seq(2'd3);
    #2;
    rstn = 1'b0;
    #1;
    push("async_reset", o(3'd0, 1'b0, 1'b0, 5'b0, 1'b0, 2'd0));
    check_now();
    repeat (2) @(posedge clk);
    #1;
    push("reset_held", o(3'd0, 1'b0, 1'b0, 5'b0, 1'b0, 2'd0));
    check_now();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/laser_safety_sequencer.md
Name: laser_safety_sequencer

Overview:
- Controller that sequences the laser pulse/current limit checker.
- Arms the laser only after a settle period, and drops laser enable on any checker fail flag or loss of laser_ready.
- Latches a sticky fault code and runs the clear handshake: pulses clear_fail into the checker, then verifies the flags have released.
- Sits between the host register interface (arm/disarm/clear requests, status readback) and the checker / laser driver enable.

Parameters:
ARM_SETTLE_CYCLES, 1000, cycles laser_ready must stay high in ARMING before enable (>=1)
CLEAR_PULSE_CYCLES, 4, width of clear_fail pulse (>=1)
CLEAR_HOLDOFF_CYCLES, 16, cycles after clear pulse before re-checking fail flags (>=1)
TRIP_CNT_W, 16, width of saturating trip counter

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
arm_req  in  1  host request to arm (level or pulse, sampled per cycle)
disarm_req  in  1  host request to disarm
clear_req  in  1  host request to clear latched fault
laser_ready  in  1  laser driver ready
pulse_lower_limit_fail  in  1  checker flag
pulse_upper_limit_fail  in  1  checker flag
rate_lower_limit_fail  in  1  checker flag
current_limit_fail  in  1  checker flag
laser_enable  out  1  registered enable to laser driver
clear_fail  out  1  registered clear strobe to checker
fault_code  out  5  sticky: [0] pulse_lower, [1] pulse_upper, [2] rate_lower, [3] current, [4] ready_lost
trip_pulse  out  1  one-cycle strobe on each entry to TRIPPED
trip_count  out  TRIP_CNT_W  saturating count of TRIPPED entries
state  out  3  current FSM state encoding

Behaviour:
- Clock and reset: one clock clk; reset rstn is asynchronous, active-low.
- Reset values: state=IDLE, laser_enable=0, clear_fail=0, fault_code=0, trip_pulse=0, trip_count=0, timer=0. Reset mid-operation drops laser_enable immediately (asynchronously).
- Definitions: any_fail = OR of the four checker flags. All outputs are registered.
- Priority within a state: fail > disarm > clear > arm.
- States: IDLE=0, ARMING=1, ARMED=2, TRIPPED=3, CLEAR_PULSE=4, CLEAR_HOLD=5.
- IDLE:
  - any_fail -> TRIPPED (latch bits).
  - else arm_req & laser_ready -> ARMING, timer=ARM_SETTLE_CYCLES-1.
  - arm_req with laser_ready low is ignored.
- ARMING:
  - any_fail -> TRIPPED.
  - disarm_req -> IDLE.
  - laser_ready low -> reload timer, stay.
  - timer==0 -> ARMED; laser_enable=1 on the same edge, so enable is high the first cycle in ARMED.
  - else timer decrements.
  - Total ARM latency: arm_req cycle plus ARM_SETTLE_CYCLES edges.
- ARMED:
  - any_fail -> TRIPPED.
  - laser_ready low -> TRIPPED with fault_code[4]=1.
  - disarm_req -> IDLE.
  - laser_enable clears on the transition edge: 1-cycle latency from fail flag to enable low.
- TRIPPED:
  - laser_enable=0.
  - fault_code |= current flags every cycle.
  - arm_req and disarm_req are ignored.
  - clear_req -> CLEAR_PULSE, timer=CLEAR_PULSE_CYCLES-1, clear_fail=1.
- CLEAR_PULSE:
  - clear_fail held high; flags ignored (the checker is being reset).
  - timer==0 -> CLEAR_HOLD, clear_fail=0, timer=CLEAR_HOLDOFF_CYCLES-1.
- CLEAR_HOLD:
  - Fail flags are not latched until the end of holdoff.
  - timer==0: any_fail=0 -> IDLE with fault_code=0; else -> TRIPPED with fault_code = previous | flags.
  - laser_ready state does not block the clear.
- Entry to TRIPPED (from any state):
  - trip_pulse=1 for exactly one cycle.
  - trip_count increments, saturating at all-ones.
  - CLEAR_HOLD -> TRIPPED counts as a new entry.
  - Remaining in TRIPPED does not re-pulse.
- Simultaneous events:
  - fail and disarm in ARMED -> TRIPPED.
  - clear_req and a new fail in TRIPPED -> CLEAR_PULSE; the new bit is still ORed that cycle.
  - Multiple flags in one cycle latch all bits.
- Timer width: $clog2 of the max of the three cycle parameters, +1.

Decomposition:
- Package laser_safety_pkg:
  - state enum (3-bit encodings above).
  - fault bit index constants FLT_PULSE_LO..FLT_READY_LOST.
  - FAULT_W=5.
- One sub-module: ctrl_timer, a loadable down-counter with load value, load strobe and zero flag, shared by ARMING/CLEAR_PULSE/CLEAR_HOLD.
- FSM, fault latch and trip counter stay in the top module.

Test Plan:
- Reset then arm (settings: ARM_SETTLE_CYCLES=8): arm_req=1 one cycle with laser_ready=1 -> state ARMING; laser_enable=1 exactly 8 edges later; state=2.
- Trip on current fail: in ARMED, current_limit_fail=1 one cycle -> next edge laser_enable=0, state=3, fault_code=5'b01000, trip_pulse one cycle, trip_count=1.
- Ready lost in ARMED: laser_ready=0 -> TRIPPED, fault_code=5'b10000; laser_ready drops for 3 cycles in ARMING -> timer reloads, enable delayed by a full 8 cycles after ready returns.
- Clean clear (settings: CLEAR_PULSE_CYCLES=4, CLEAR_HOLDOFF_CYCLES=16; flags released): clear_req in TRIPPED -> clear_fail high exactly 4 cycles, 16 holdoff cycles, then IDLE with fault_code=0.
- Sticky clear: rate_lower_limit_fail held high through the clear -> after holdoff state returns to TRIPPED, fault_code[2]=1, trip_count increments, second trip_pulse.
- Saturation and async reset (TRIP_CNT_W=2): 5 trip/clear loops -> trip_count stays 3; rstn low mid-ARMED -> laser_enable 0 without a clock edge, all outputs at reset values.
